// File: rtl/obf_pkg.sv
// Shared types and defaults for the obfuscation key controller and its key shifter.
package obf_pkg;

  localparam int DEFAULT_KEY_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    UNLOCKED,
    LOCKOUT
  } obf_ctrl_state_t;

endpackage

// File: rtl/obf_key_shifter.sv
// Serial-in, MSB-first key shift register with an accepted-bit counter.
// last_bit flags that the next accepted bit completes the key.
module obf_key_shifter
  import obf_pkg::*;
#(
  parameter int KEY_WIDTH = DEFAULT_KEY_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 shift_en,
  input  logic                 bit_in,
  output logic [KEY_WIDTH-1:0] shreg,
  output logic                 last_bit
);

  localparam int CW = $clog2(KEY_WIDTH);

  logic [KEY_WIDTH-1:0] shreg_reg;
  logic [KEY_WIDTH-1:0] shreg_next;
  logic [CW-1:0]        cnt_reg;

  // New bit enters at the LSB so the first (MSB) bit ends up on top.
  assign shreg_next[0] = bit_in;
  generate
    for (genvar gi = 1; gi < KEY_WIDTH; gi++) begin : g_shift
      assign shreg_next[gi] = shreg_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_reg <= '0;
      cnt_reg   <= '0;
    end else if (clr) begin
      shreg_reg <= '0;
      cnt_reg   <= '0;
    end else if (shift_en) begin
      shreg_reg <= shreg_next;
      cnt_reg   <= cnt_reg + 1'b1;
    end
  end

  assign shreg    = shreg_reg;
  assign last_bit = (cnt_reg == CW'(KEY_WIDTH - 1));

endmodule

// File: rtl/obfuscation_key_controller.sv
// Unlock controller for Key/GKey obfuscation cells: serial key attempt, golden-key
// compare, fail counting with permanent lockout; Key is driven only while unlocked.
module obfuscation_key_controller
  import obf_pkg::*;
#(
  parameter int                   KEY_WIDTH  = DEFAULT_KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] GOLDEN_KEY = 8'hA5,
  parameter logic [KEY_WIDTH-1:0] GKEY_VALUE = 8'h3C,
  parameter int                   MAX_FAIL   = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             key_in,
  input  logic                             key_in_valid,
  output logic                             key_in_ready,
  output logic [KEY_WIDTH-1:0]             key,
  output logic [KEY_WIDTH-1:0]             gkey,
  output logic                             unlocked,
  output logic                             lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_count
);

  localparam int FCW = $clog2(MAX_FAIL + 1);
  localparam logic [FCW-1:0] MAX_FAIL_C = FCW'(MAX_FAIL);

  obf_ctrl_state_t      state_reg, state_next;
  logic [KEY_WIDTH-1:0] key_reg, key_next;
  logic [KEY_WIDTH-1:0] gkey_reg;
  logic                 unlocked_reg, unlocked_next;
  logic                 lockout_reg, lockout_next;
  logic [FCW-1:0]       fail_count_reg, fail_count_next;
  logic [FCW-1:0]       fail_inc;
  logic                 sh_clr, sh_en, sh_last;
  logic [KEY_WIDTH-1:0] shreg;

  obf_key_shifter #(
    .KEY_WIDTH(KEY_WIDTH)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (sh_clr),
    .shift_en(sh_en),
    .bit_in  (key_in),
    .shreg   (shreg),
    .last_bit(sh_last)
  );

  assign fail_inc = (fail_count_reg == MAX_FAIL_C) ? fail_count_reg : fail_count_reg + 1'b1;

  always_comb begin
    state_next      = state_reg;
    key_next        = key_reg;
    unlocked_next   = unlocked_reg;
    lockout_next    = lockout_reg;
    fail_count_next = fail_count_reg;
    sh_clr          = 1'b0;
    sh_en           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          sh_clr     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        sh_en = key_in_valid;
        if (key_in_valid && sh_last) state_next = CHECK;
      end
      CHECK: begin
        if (shreg == GOLDEN_KEY) begin
          key_next        = shreg;
          unlocked_next   = 1'b1;
          fail_count_next = '0;
          state_next      = UNLOCKED;
        end else begin
          fail_count_next = fail_inc;
          if (fail_inc == MAX_FAIL_C) begin
            lockout_next = 1'b1;
            state_next   = LOCKOUT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      UNLOCKED: begin
        // A new attempt withdraws the key before any bit is shifted in.
        if (start) begin
          key_next      = '0;
          unlocked_next = 1'b0;
          sh_clr        = 1'b1;
          state_next    = SHIFT;
        end
      end
      LOCKOUT: ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      key_reg        <= '0;
      gkey_reg       <= GKEY_VALUE;
      unlocked_reg   <= 1'b0;
      lockout_reg    <= 1'b0;
      fail_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      key_reg        <= key_next;
      gkey_reg       <= GKEY_VALUE;
      unlocked_reg   <= unlocked_next;
      lockout_reg    <= lockout_next;
      fail_count_reg <= fail_count_next;
    end
  end

  assign key_in_ready = (state_reg == SHIFT);
  assign key          = key_reg;
  assign gkey         = gkey_reg;
  assign unlocked     = unlocked_reg;
  assign lockout      = lockout_reg;
  assign fail_count   = fail_count_reg;

endmodule

// File: tb/tb_obfuscation_key_controller.sv
// Directed bench for obfuscation_key_controller: attempts are modelled when driven,
// expected results are queued and popped when the DUT publishes its verdict.
module tb_obfuscation_key_controller;

  localparam logic [7:0] GOLDEN = 8'hA5;
  localparam logic [7:0] GKEYV  = 8'h3C;
  localparam int         MAXF   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       key_in = 1'b0;
  logic       key_in_valid = 1'b0;
  logic       key_in_ready;
  logic [7:0] key;
  logic [7:0] gkey;
  logic       unlocked;
  logic       lockout;
  logic [1:0] fail_count;

  obfuscation_key_controller #(
    .KEY_WIDTH (8),
    .GOLDEN_KEY(GOLDEN),
    .GKEY_VALUE(GKEYV),
    .MAX_FAIL  (MAXF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .key_in      (key_in),
    .key_in_valid(key_in_valid),
    .key_in_ready(key_in_ready),
    .key         (key),
    .gkey        (gkey),
    .unlocked    (unlocked),
    .lockout     (lockout),
    .fail_count  (fail_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       unl;
    logic [7:0] key;
    logic [1:0] fc;
    logic       lck;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mdl_fc = 0;
  bit   mdl_lock = 0;
  bit   mdl_unl = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mdl_fc   = 0;
    mdl_lock = 0;
    mdl_unl  = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(key_in_ready), 0);
    chk({tag, "_key"}, 32'(key), 0);
    chk({tag, "_gkey"}, 32'(gkey), 32'(GKEYV));
    chk({tag, "_unl"}, 32'(unlocked), 0);
    chk({tag, "_lck"}, 32'(lockout), 0);
    chk({tag, "_fc"}, 32'(fail_count), 0);
  endtask

  // One full attempt: Start pulse, eight MSB-first bits, CHECK, then the verdict.
  task automatic attempt(input logic [7:0] k, input bit toggle, input string tag);
    exp_t e;
    exp_t got;
    bit   was_locked;
    bit   was_unl;
    was_locked = mdl_lock;
    was_unl    = mdl_unl;
    if (mdl_lock) begin
      e = '{tag, 1'b0, 8'h00, 2'(mdl_fc), 1'b1};
    end else if (k == GOLDEN) begin
      mdl_fc = 0;
      e = '{tag, 1'b1, GOLDEN, 2'd0, 1'b0};
    end else begin
      if (mdl_fc < MAXF) mdl_fc++;
      mdl_lock = (mdl_fc == MAXF);
      e = '{tag, 1'b0, 8'h00, 2'(mdl_fc), mdl_lock};
    end
    sb.push_back(e);

    // A bit offered alongside Start must be ignored; offer the wrong value.
    start        = 1'b1;
    key_in_valid = 1'b1;
    key_in       = ~k[7];
    tick();
    start        = 1'b0;
    key_in_valid = 1'b0;
    chk({tag, "_ready_after_start"}, 32'(key_in_ready), was_locked ? 0 : 1);
    if (was_unl) begin
      chk({tag, "_relock_unl"}, 32'(unlocked), 0);
      chk({tag, "_relock_key"}, 32'(key), 0);
    end
    for (int i = 7; i >= 0; i--) begin
      if (toggle && i != 7) begin
        key_in_valid = 1'b0;
        key_in       = ~k[i];
        start        = 1'b1;
        tick();
        start        = 1'b0;
      end
      key_in_valid = 1'b1;
      key_in       = k[i];
      tick();
    end
    key_in_valid = 1'b0;
    // CHECK cycle: verdict not yet visible, no bits accepted.
    chk({tag, "_check_ready"}, 32'(key_in_ready), 0);
    chk({tag, "_check_unl"}, 32'(unlocked), 0);
    tick();
    got = sb.pop_front();
    chk({got.tag, "_unl"}, 32'(unlocked), 32'(got.unl));
    chk({got.tag, "_key"}, 32'(key), 32'(got.key));
    chk({got.tag, "_fc"}, 32'(fail_count), 32'(got.fc));
    chk({got.tag, "_lck"}, 32'(lockout), 32'(got.lck));
    chk({got.tag, "_gkey"}, 32'(gkey), 32'(GKEYV));
    mdl_unl = got.unl;
    $display("attempt %s key=%02h unlocked=%0b key_out=%02h fail_count=%0d lockout=%0b",
             got.tag, k, unlocked, key, fail_count, lockout);
  endtask

  initial begin
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    model_reset();

    attempt(8'hA5, 1'b0, "correct");
    attempt(8'hFF, 1'b0, "relock_wrong");
    attempt(8'hA4, 1'b0, "wrong_a4");
    attempt(8'hA5, 1'b0, "correct_after_wrong");
    attempt(8'hA5, 1'b1, "toggled_valid");
    attempt(8'h00, 1'b0, "fail_before_rst");

    // Abort mid-key with an asynchronous reset between clock edges.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 7; i >= 4; i--) begin
      key_in_valid = 1'b1;
      key_in       = GOLDEN[i];
      tick();
    end
    key_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    $display("async reset mid-shift fail_count=%0d ready=%0b", fail_count, key_in_ready);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    model_reset();
    attempt(8'hA5, 1'b0, "correct_after_rst");

    // Drive to lockout from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    model_reset();
    attempt(8'h00, 1'b0, "zero_1");
    attempt(8'h00, 1'b0, "zero_2");
    attempt(8'h00, 1'b0, "zero_3");
    attempt(8'hA5, 1'b0, "locked_correct");
    rst_n = 1'b0;
    #1 check_reset_values("lockout_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    model_reset();
    attempt(8'hA5, 1'b0, "correct_after_lockout");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
